muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with HI/LO registers for the MIPS64 core, alongside the ALU decode path.
- Decodes R-type funct codes for MULT/DIV-class instructions and runs a shift-add multiply or restoring divide over several cycles.
- Exposes busy/done handshake so the hazard unit can stall MFHI/MFLO and a new muldiv op until the result is ready.
- Parametrised in datapath width; 64-bit builds add the D-variants.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_if.sv | 31 +++
 rtl/muldiv_decode.sv | 41 ++++
 rtl/muldiv_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct codes,
// FSM states, operation classes and the decoder result struct.
package muldiv_pkg;

  localparam logic [5:0] F_MTHI   = 6'b010001;
  localparam logic [5:0] F_MTLO   = 6'b010011;
  localparam logic [5:0] F_MULT   = 6'b011000;
  localparam logic [5:0] F_MULTU  = 6'b011001;
  localparam logic [5:0] F_DIV    = 6'b011010;
  localparam logic [5:0] F_DIVU   = 6'b011011;
  localparam logic [5:0] F_DMULT  = 6'b011100;
  localparam logic [5:0] F_DMULTU = 6'b011101;
  localparam logic [5:0] F_DDIV   = 6'b011110;
  localparam logic [5:0] F_DDIVU  = 6'b011111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  typedef enum logic [2:0] {
    OP_MUL,
    OP_DIV,
    OP_MTHI,
    OP_MTLO,
    OP_BAD
  } op_e;

  typedef struct packed {
    op_e  op;
    logic is_signed;
    logic is_double;
  } dec_t;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the issuing stage and muldiv_unit, plus a
// debug view of the FSM state.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 64
) ();
  // Handshake: start is a valid, !busy is the ready. A request is taken on a
  // rising edge where start && !busy; start while busy is dropped, so the
  // issuer holds off until busy falls. done/illegal are one-cycle pulses.
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             illegal;
  state_e           dbg_state;

  modport master (
    output start, funct, srca, srcb,
    input  busy, done, hi, lo, illegal, dbg_state
  );

  modport slave (
    input  start, funct, srca, srcb,
    output busy, done, hi, lo, illegal, dbg_state
  );
endinterface

// File: rtl/muldiv_decode.sv
// Combinational funct decoder; also used by the hazard unit to spot HI/LO
// dependencies. D-variants decode as OP_BAD in 32-bit builds.
module muldiv_decode
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [5:0] funct,
  output dec_t       dec
);

  localparam logic HAS_D = (WIDTH == 64);

  always_comb begin
    dec.op        = OP_BAD;
    dec.is_signed = 1'b0;
    dec.is_double = 1'b0;
    case (funct)
      F_MULT:   begin dec.op = OP_MUL; dec.is_signed = 1'b1; end
      F_MULTU:  begin dec.op = OP_MUL; end
      F_DIV:    begin dec.op = OP_DIV; dec.is_signed = 1'b1; end
      F_DIVU:   begin dec.op = OP_DIV; end
      F_DMULT: begin
        if (HAS_D) begin dec.op = OP_MUL; dec.is_signed = 1'b1; dec.is_double = 1'b1; end
      end
      F_DMULTU: begin
        if (HAS_D) begin dec.op = OP_MUL; dec.is_double = 1'b1; end
      end
      F_DDIV: begin
        if (HAS_D) begin dec.op = OP_DIV; dec.is_signed = 1'b1; dec.is_double = 1'b1; end
      end
      F_DDIVU: begin
        if (HAS_D) begin dec.op = OP_DIV; dec.is_double = 1'b1; end
      end
      F_MTHI:   dec.op = OP_MTHI;
      F_MTLO:   dec.op = OP_MTLO;
      default:  dec.op = OP_BAD;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN: multiply finishes once no multiplier bits remain.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int WORD  = 32
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  dec_t dec;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_mul_q, is_mul_d;
  logic             is_dbl_q, is_dbl_d;
  logic             div0_q, div0_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  logic [WORD-1:0]  a_w, b_w, a_w_mag, b_w_mag;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b, dividend_init;
  logic [WIDTH:0]   div_part, div_diff;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quot_s, rem_s, fix_hi, fix_lo;

  function automatic logic [WIDTH-1:0] sext_word(input logic [WORD-1:0] v);
    return WIDTH'($signed(v));
  endfunction

  muldiv_decode #(.WIDTH(WIDTH)) u_decode (
    .funct (bus.funct),
    .dec   (dec)
  );

  // Operand magnitudes; word ops look only at the low WORD bits.
  always_comb begin
    a_w     = bus.srca[WORD-1:0];
    b_w     = bus.srcb[WORD-1:0];
    a_w_mag = (dec.is_signed && a_w[WORD-1]) ? -a_w : a_w;
    b_w_mag = (dec.is_signed && b_w[WORD-1]) ? -b_w : b_w;
    if (dec.is_double) begin
      sign_a = dec.is_signed & bus.srca[WIDTH-1];
      sign_b = dec.is_signed & bus.srcb[WIDTH-1];
      mag_a  = sign_a ? -bus.srca : bus.srca;
      mag_b  = sign_b ? -bus.srcb : bus.srcb;
    end else begin
      sign_a = dec.is_signed & a_w[WORD-1];
      sign_b = dec.is_signed & b_w[WORD-1];
      mag_a  = WIDTH'(a_w_mag);
      mag_b  = WIDTH'(b_w_mag);
    end
    // Left-align word dividends so the quotient always shifts out of the MSB.
    dividend_init = dec.is_double ? mag_a : (mag_a << (WIDTH - WORD));
  end

  // Restoring divide step: acc holds {remainder, dividend/quotient}.
  assign div_part = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_part - {1'b0, opb_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_mul_d  = is_mul_q;
    is_dbl_d  = is_dbl_q;
    div0_d    = div0_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (dec.op)
            OP_MTHI: begin
              hi_d   = bus.srca;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus.srca;
              done_d = 1'b1;
            end
            OP_MUL, OP_DIV: begin
              is_mul_d = (dec.op == OP_MUL);
              is_dbl_d = dec.is_double;
              div0_d   = 1'b0;
              neg_lo_d = sign_a ^ sign_b;
              neg_hi_d = sign_a;
              opb_d    = mag_b;
              cnt_d    = dec.is_double ? CW'(WIDTH - 1) : CW'(WORD - 1);
              state_d  = RUN;
              if (dec.op == OP_MUL) begin
                acc_d = '0;
                opa_d = W2'(mag_a);
`ifdef MULDIV_EARLY_OUT_EN
                if (mag_b == '0) state_d = FIX;
`endif
              end else begin
                opa_d = '0;
                acc_d = W2'(dividend_init);
                if (mag_b == '0) begin
                  div0_d  = 1'b1;
                  acc_d   = W2'(bus.srca);
                  state_d = FIX;
                end
              end
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end

      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_mul_q) begin
          if (opb_q[0]) acc_d = acc_q + opa_q;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
`ifdef MULDIV_EARLY_OUT_EN
          if (opb_q[WIDTH-1:1] == '0) state_d = FIX;
`endif
        end else begin
          if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                  acc_d = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = FIX;
      end

      FIX: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Sign correction and word sign-extension of the final result.
  always_comb begin
    prod   = neg_lo_q ? -acc_q : acc_q;
    quot_s = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s  = neg_hi_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    if (div0_q) begin
      fix_lo = '1;
      fix_hi = is_dbl_q ? acc_q[WIDTH-1:0] : sext_word(acc_q[WORD-1:0]);
    end else if (is_mul_q) begin
      if (is_dbl_q) begin
        fix_lo = prod[WIDTH-1:0];
        fix_hi = prod[W2-1:WIDTH];
      end else begin
        fix_lo = sext_word(prod[WORD-1:0]);
        fix_hi = sext_word(prod[2*WORD-1:WORD]);
      end
    end else begin
      fix_lo = is_dbl_q ? quot_s : sext_word(quot_s[WORD-1:0]);
      fix_hi = is_dbl_q ? rem_s  : sext_word(rem_s[WORD-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_mul_q  <= 1'b0;
      is_dbl_q  <= 1'b0;
      div0_q    <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_mul_q  <= is_mul_d;
      is_dbl_q  <= is_dbl_d;
      div0_q    <= div0_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.illegal   = illegal_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=64): directed cases plus random
// ops against an arithmetic reference model, results checked via a scoreboard.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int WIDTH = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH), .WORD(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q[$];
  logic [63:0]  model_hi = '0;
  logic [63:0]  model_lo = '0;
  logic [127:0] mon_e;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [127:0] ref_result(input logic [5:0] f, input logic [63:0] a,
                                               input logic [63:0] b, input logic [63:0] cur_hi,
                                               input logic [63:0] cur_lo);
    logic signed [127:0] sa, sb, sp, sq, sr;
    logic [127:0] up;
    logic [63:0]  rh, rl;
    rh = cur_hi;
    rl = cur_lo;
    case (f)
      F_MULT: begin
        sa = 128'($signed(a[31:0])); sb = 128'($signed(b[31:0]));
        sp = sa * sb;
        rl = sx32(sp[31:0]); rh = sx32(sp[63:32]);
      end
      F_MULTU: begin
        up = {96'b0, a[31:0]} * {96'b0, b[31:0]};
        rl = sx32(up[31:0]); rh = sx32(up[63:32]);
      end
      F_DIV: begin
        if (b[31:0] == 32'b0) begin rl = '1; rh = sx32(a[31:0]); end
        else begin
          sa = 128'($signed(a[31:0])); sb = 128'($signed(b[31:0]));
          sq = sa / sb; sr = sa % sb;
          rl = sx32(sq[31:0]); rh = sx32(sr[31:0]);
        end
      end
      F_DIVU: begin
        if (b[31:0] == 32'b0) begin rl = '1; rh = sx32(a[31:0]); end
        else begin
          up = {96'b0, a[31:0] / b[31:0]}; rl = sx32(up[31:0]);
          up = {96'b0, a[31:0] % b[31:0]}; rh = sx32(up[31:0]);
        end
      end
      F_DMULT: begin
        sa = 128'($signed(a)); sb = 128'($signed(b));
        sp = sa * sb;
        rl = sp[63:0]; rh = sp[127:64];
      end
      F_DMULTU: begin
        up = {64'b0, a} * {64'b0, b};
        rl = up[63:0]; rh = up[127:64];
      end
      F_DDIV: begin
        if (b == 64'b0) begin rl = '1; rh = a; end
        else begin
          sa = 128'($signed(a)); sb = 128'($signed(b));
          sq = sa / sb; sr = sa % sb;
          rl = sq[63:0]; rh = sr[63:0];
        end
      end
      F_DDIVU: begin
        if (b == 64'b0) begin rl = '1; rh = a; end
        else begin rl = a / b; rh = a % b; end
      end
      F_MTHI: rh = a;
      F_MTLO: rl = a;
      default: ;
    endcase
    return {rh, rl};
  endfunction

  function automatic int ref_lat(input logic [5:0] f, input logic [63:0] b);
    logic        dbl, sgn, is_div;
    logic [63:0] m;
    logic [31:0] bw;
    int          n;
    int          h;
    if (f == F_MTHI || f == F_MTLO) return 1;
    dbl    = (f == F_DMULT || f == F_DMULTU || f == F_DDIV || f == F_DDIVU);
    sgn    = (f == F_MULT || f == F_DIV || f == F_DMULT || f == F_DDIV);
    is_div = (f == F_DIV || f == F_DIVU || f == F_DDIV || f == F_DDIVU);
    n      = dbl ? 64 : 32;
    bw     = b[31:0];
    if (dbl) m = (sgn && b[63]) ? -b : b;
    else begin
      if (sgn && bw[31]) bw = -bw;
      m = {32'b0, bw};
    end
    if (is_div) return (m == 64'b0) ? 2 : n + 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (m == 64'b0) return 2;
    h = 0;
    for (int i = 0; i < 64; i++) if (m[i]) h = i;
    return h + 3;
`else
    h = n + 2;
    return h;
`endif
  endfunction

  task automatic drive_start(input logic [5:0] f, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct = f;
    bus.srca  = a;
    bus.srcb  = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input int lat0);
    int lat;
    lat = lat0;
    while (!bus.done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 128'(lat), 128'(exp_lat));
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [63:0] a,
                        input logic [63:0] b);
    logic [127:0] e;
    int l;
    e = ref_result(f, a, b, model_hi, model_lo);
    l = ref_lat(f, b);
    exp_q.push_back(e);
    model_hi = e[127:64];
    model_lo = e[63:0];
    drive_start(f, a, b);
    check_eq({tag, "_busy"}, 128'(bus.busy), 128'(l > 1));
    wait_done(tag, l, 1);
  endtask

  // Scoreboard: every done pulse retires the oldest expected {hi, lo}.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        check_eq("done_without_pending", 128'(bus.done), 128'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("hi", 128'(bus.hi), 128'(mon_e[127:64]));
        check_eq("lo", 128'(bus.lo), 128'(mon_e[63:0]));
      end
    end
  end

  logic [5:0] rand_f [10];

  initial begin
    logic [127:0] e;
    logic [63:0]  ra, rb;
    rand_f = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_DMULT, F_DMULTU, F_DDIV, F_DDIVU, F_MTHI, F_MTLO};
    bus.start = 1'b0;
    bus.funct = 6'b0;
    bus.srca  = '0;
    bus.srcb  = '0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check_eq("reset_hi", 128'(bus.hi), 128'(0));
    check_eq("reset_lo", 128'(bus.lo), 128'(0));
    check_eq("reset_busy", 128'(bus.busy), 128'(0));
    check_eq("reset_done", 128'(bus.done), 128'(0));
    check_eq("reset_illegal", 128'(bus.illegal), 128'(0));
    check_eq("reset_state", 128'(bus.dbg_state), 128'(IDLE));

    run_op("mult_neg", F_MULT, -64'sd3, 64'd7);
    run_op("ddivu", F_DDIVU, 64'd100, 64'd7);
    run_op("ddiv_neg", F_DDIV, -64'sd7, 64'd2);
    run_op("div_by_zero", F_DIV, 64'd5, 64'd0);
    run_op("mtu_early", F_MULTU, 64'd5, 64'd1);

    // Second start while busy must be dropped.
    e = ref_result(F_DDIVU, 64'd1000, 64'd7, model_hi, model_lo);
    exp_q.push_back(e);
    model_hi = e[127:64];
    model_lo = e[63:0];
    drive_start(F_DDIVU, 64'd1000, 64'd7);
    repeat (3) @(negedge clk);
    drive_start(F_MULTU, 64'd2, 64'd3);
    check_eq("ignored_start_busy", 128'(bus.busy), 128'(1));
    wait_done("busy_ignore", ref_lat(F_DDIVU, 64'd7), 6);
    run_op("multu_reissue", F_MULTU, 64'd2, 64'd3);

    // Illegal funct: one-cycle pulse, nothing else changes.
    drive_start(6'b100000, 64'd11, 64'd22);
    check_eq("illegal_pulse", 128'(bus.illegal), 128'(1));
    check_eq("illegal_busy", 128'(bus.busy), 128'(0));
    check_eq("illegal_hi", 128'(bus.hi), 128'(model_hi));
    check_eq("illegal_lo", 128'(bus.lo), 128'(model_lo));
    @(negedge clk);
    check_eq("illegal_drop", 128'(bus.illegal), 128'(0));
    check_eq("illegal_state", 128'(bus.dbg_state), 128'(IDLE));

    // Reset in the middle of a long DMULT discards the operation.
    drive_start(F_DMULT, 64'd3, 64'h8000_0000_0000_0005);
    repeat (9) @(negedge clk);
    check_eq("pre_reset_state", 128'(bus.dbg_state), 128'(RUN));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    check_eq("midreset_busy", 128'(bus.busy), 128'(0));
    check_eq("midreset_hi", 128'(bus.hi), 128'(0));
    check_eq("midreset_lo", 128'(bus.lo), 128'(0));
    check_eq("midreset_done", 128'(bus.done), 128'(0));
    run_op("mtlo", F_MTLO, 64'h1234, 64'd0);
    repeat (70) @(negedge clk);
    run_op("mthi", F_MTHI, 64'hdead_beef_0bad_f00d, 64'd0);

    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) rb = 64'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) ra = 64'($urandom_range(0, 255));
      run_op("rand", rand_f[$urandom_range(0, 9)], ra, rb);
    end

    repeat (5) @(negedge clk);
    check_eq("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
